// File: rtl/fds_audio_lpf.sv
// FDS expansion-audio output filter: two cascaded one-pole low-pass stages,
// a box decimator and a valid/ready sample port toward the system mixer.
module fds_audio_lpf #(
    parameter int SHIFT1     = 4,
    parameter int SHIFT2     = 4,
    parameter int DECIM_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m2,
    input  logic        enable,
    input  logic [11:0] audio_in,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun
);

    localparam int DW = 16 + DECIM_LOG2;

    logic                   old_m2;
    logic                   tick;
    logic [15:0]            x16;
    logic [15:0]            acc1;
    logic [15:0]            acc2;
    logic signed [16:0]     diff1;
    logic signed [16:0]     diff2;
    logic [15:0]            step1;
    logic [15:0]            step2;
    logic [DW-1:0]          dsum;
    logic [DW-1:0]          dsum_full;
    logic [DECIM_LOG2-1:0]  dcnt;
    logic                   last;
    logic [15:0]            p;
    logic                   produce;
    logic                   accept;

    assign tick = m2 & ~old_m2;

    // Disabled audio is a zero input; the filter then decays on its own.
    assign x16 = enable ? {audio_in, 4'b0000} : 16'd0;

    // Both stages step by floor(diff / 2^SHIFT). The true result always
    // lies in 0..65535, so a 16-bit wrap-around add of the step is exact.
    assign diff1 = $signed({1'b0, x16}) - $signed({1'b0, acc1});
    assign diff2 = $signed({1'b0, acc1}) - $signed({1'b0, acc2});
    assign step1 = 16'(diff1 >>> SHIFT1);
    assign step2 = 16'(diff2 >>> SHIFT2);

    assign last      = &dcnt;
    assign dsum_full = dsum + DW'(acc2);
    assign p         = 16'(dsum_full >> DECIM_LOG2);
    assign produce   = tick & last;
    assign accept    = sample_valid & sample_ready;

    // Remember the previous M2 level so a held-high M2 yields one tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_m2 <= 1'b0;
        end else begin
            old_m2 <= m2;
        end
    end

    // Cascaded one-pole stages; stage 2 follows the pre-tick stage-1 value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc1 <= 16'd0;
            acc2 <= 16'd0;
        end else if (tick) begin
            acc1 <= acc1 + step1;
            acc2 <= acc2 + step2;
        end
    end

    // Box decimator: sum 2^DECIM_LOG2 pre-tick stage-2 values per window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsum <= '0;
            dcnt <= '0;
        end else if (tick) begin
            if (last) begin
                dsum <= '0;
                dcnt <= '0;
            end else begin
                dsum <= dsum_full;
                dcnt <= dcnt + DECIM_LOG2'(1);
            end
        end
    end

    // Output register: a held unaccepted sample is never overwritten; a new
    // sample arriving then is dropped and flagged until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out   <= 16'd0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (produce && (!sample_valid || sample_ready)) begin
                sample_out   <= p;
                sample_valid <= 1'b1;
            end else if (accept) begin
                sample_valid <= 1'b0;
            end
            if (produce && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fds_audio_lpf.md
# fds_audio_lpf

Post-processing stage for the FDS expansion-audio channel. It consumes the 12-bit unsigned `audio_out` from the FDS audio generator and applies a two-pole cascaded one-pole low-pass that approximates the cartridge RC output filter. It then box-decimates the result and hands 16-bit unsigned samples to the system audio mixer over a valid/ready handshake. It runs on the system clock and advances only on M2 rising edges, the same cadence as the generator.

## Interface
Parameters:
- `SHIFT1`, default 4: stage-1 coefficient exponent, giving k = 2^-SHIFT1. Legal range 1..8.
- `SHIFT2`, default 4: stage-2 coefficient exponent. Legal range 1..8.
- `DECIM_LOG2`, default 5: decimation ratio 2^DECIM_LOG2 ticks per output sample. Legal range 1..8.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `m2`  in  1  CPU M2 phase; rising edge defines a tick.
- `enable`  in  1  FDS audio present; when 0, the input is treated as 0.
- `audio_in`  in  12  unsigned level from the FDS audio generator.
- `sample_out`  out  16  unsigned 12.4 fixed-point decimated sample.
- `sample_valid`  out  1  sample_out holds an unaccepted sample.
- `sample_ready`  in  1  mixer accepts the sample when valid & ready at a clk edge.
- `overrun`  out  1  sticky; set when a produced sample was dropped.

## Operation
- Edge detect: `old_m2` is a register with reset value 0. tick = m2 & ~old_m2. An M2 held high produces exactly one tick.
- Input: x = enable ? audio_in : 0, extended to 16 bits as x<<4 (12.4 format).
- Stage 1 (acc1, 16 bits): diff1 = (x<<4) − acc1, 17-bit signed. acc1 += diff1 >>> SHIFT1, using an arithmetic shift (floor).
- Stage 2 (acc2, 16 bits): same form, using the *pre-tick* acc1 as its input and SHIFT2.
- Floor rounding bound: in steady state with a constant input X, each acc settles in [X − (2^SHIFT − 1), X]. No accumulator ever overflows 16 bits or goes below 0.
- Decimator:
  - dsum is 16+DECIM_LOG2 bits; dcnt is DECIM_LOG2 bits.
  - Each tick adds the pre-tick acc2 to dsum and increments dcnt.
  - On the tick where dcnt is all ones, the block produces P = (dsum + acc2) >> DECIM_LOG2. On that same tick, dsum is cleared to 0 and dcnt wraps to 0.
- Output handshake:
  - If sample_valid = 0, P loads into sample_out and sample_valid is set.
  - If sample_valid = 1 and sample_ready = 1 on the same edge, the held sample is accepted, P loads, and valid stays 1. This is not an overrun.
  - If sample_valid = 1 and sample_ready = 0, P is discarded, the held sample_out stays stable, and overrun is set.
  - Any accept edge with no new P present clears sample_valid.
  - Every accept edge clears overrun unless the same edge also sets it.
  - sample_out never changes while sample_valid = 1 and the sample is unaccepted.
- `enable` falling: the filter decays toward 0 naturally. There is no flush.

## Timing
- Reset values: acc1, acc2, dsum, dcnt and old_m2 are 0. sample_out = 0, sample_valid = 0, overrun = 0.
- All state updates occur at the clk edge during which tick = 1. Between ticks, only the handshake logic responds to sample_ready.
- Pipeline: audio_in sampled at tick n affects acc1 after tick n, acc2 after tick n+1, and dsum from tick n+2.
- sample_valid rises at the clk edge of the 2^DECIM_LOG2-th tick after reset. It then recurs every 2^DECIM_LOG2 ticks when ready is held at 1.
- Reset asserted mid-operation, including mid-handshake, clears everything asynchronously. The first tick after deassertion starts a fresh decimation window.

## Test plan
- Reset: assert reset mid-run with valid = 1 -> sample_out = 0, sample_valid = 0 and overrun = 0 immediately, without waiting for a clock edge.
- Step response with defaults, audio_in = 4095, enable = 1:
  - after tick 1 -> acc1 = 4095, acc2 = 0.
  - after tick 2 -> acc1 = 7934, acc2 = 255.
- Cadence: constant audio_in = 0, ready = 1 -> valid pulses for exactly 1 clk every 32 ticks, with sample_out = 0. An M2 held high for 100 clk counts as one tick.
- Convergence: audio_in = 2048 for 2000 ticks -> sample_out in [32738, 32768]. Then set enable = 0 -> samples decrease monotonically to 0.
- Backpressure: ready = 0 across two production ticks -> first sample held stable, second dropped, overrun = 1. Raising ready for 1 clk -> valid = 0 and overrun = 0.
- Simultaneous accept/produce: ready = 1 exactly on the production edge while valid = 1 -> new sample loaded, valid stays 1, overrun stays 0.
